mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 16-bit memory port between instruction fetch and the execute-stage
//  load/store path (readEnable/writeEnable, Address, storeData).
//  Fixed priority to data over fetch; one access in flight; per-requester req/ack handshake.
//  Sits between the pipeline stages and the memory.
// PARAMETERS
//  MEM_LATENCY   2   cycles from mem_re high until mem_rdata is valid (>=1)
//  MAX_STREAK    4   data grants in a row allowed while fetch waits (only with ARB_FAIRNESS_EN)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  if_req      in   1   fetch read request; held until if_ack
//  if_addr     in   16  fetch address; stable while if_req
//  if_ack      out  1   one-cycle pulse: fetch done, if_rdata valid
//  if_rdata    out  16  fetched word; held until next fetch ack
//  d_rd        in   1   data read request (execute readEnable); held until d_ack
//  d_wr        in   1   data write request (execute writeEnable); held until d_ack
//  d_addr      in   16  data address
//  d_wdata     in   16  store data
//  d_ack       out  1   one-cycle pulse: data access done
//  d_rdata     out  16  load data; valid with d_ack on reads, held afterwards
//  mem_addr    out  16  memory address
//  mem_wdata   out  16  memory write data
//  mem_re      out  1   memory read strobe, one cycle per read
//  mem_we      out  1   memory write strobe, one cycle per write
//  mem_rdata   in   16  memory read data
//  stall_if    out  1   if_req & ~if_ack (combinational)
//  stall_d     out  1   (d_rd|d_wr) & ~d_ack (combinational)
//  rw_err      out  1   sticky: d_rd and d_wr sampled high together; cleared by reset only
// BEHAVIOUR
//  - Reset: state IDLE; all registered outputs 0 (if_ack, d_ack, if_rdata, d_rdata,
//    mem_addr, mem_wdata, mem_re, mem_we, rw_err); latency counter 0; streak counter 0.
//  - FSM states: IDLE, ISSUE, WAIT, ACK.
//  - IDLE: sample requests. Data is selected if d_rd|d_wr, otherwise fetch if if_req.
//    Latch the selection, mem_addr and mem_wdata, then go to ISSUE. With no request, stay.
//  - ISSUE (1 cycle): mem_re=1 on reads, mem_we=1 on writes.
//    Reads go to WAIT, counter loaded with MEM_LATENCY-1. Writes go to ACK.
//  - WAIT: decrement the counter. When it reaches 0, capture mem_rdata into
//    if_rdata/d_rdata of the granted side and go to ACK.
//  - ACK (1 cycle): pulse the granted ack, then go to IDLE.
//    Requests are not sampled in ACK, so the acked requester can drop its request.
//  - Timing, request first seen in IDLE at cycle 0:
//    mem_re/mem_we at cycle 1; write ack at cycle 2; read ack at cycle 2+MEM_LATENCY.
//  - Simultaneous d_rd and d_wr: the write is performed; rw_err is set.
//  - Simultaneous data and fetch in IDLE: data wins; fetch waits and stall_if stays high.
//  - Request dropped before its ack (protocol violation): the access completes and is acked.
//  - Reset mid-access: the access is abandoned, no ack, mem_re/mem_we forced to 0.
//  - Address and data are 16 bits and passed through unchanged; no arithmetic on them.
// CONFIGURATION
//  ARB_FAIRNESS_EN defined:
//   - streak counter increments on each data grant made while if_req is high.
//   - counter clears on each fetch grant.
//   - when counter == MAX_STREAK and if_req is high, the next IDLE grant goes to fetch even if data requests.
//  ARB_FAIRNESS_EN undefined: strict data priority; streak logic absent; MAX_STREAK unused.
// TESTING
//  1. Reset with if_req=1 and d_rd=1 -> all outputs 0; release rst_n -> grant data, mem_re at cycle 1.
//  2. if_req only, if_addr=16'h0010, mem returns 16'hBEEF, MEM_LATENCY=2
//     -> if_ack at cycle 4, if_rdata=16'hBEEF, stall_if low afterwards.
//  3. d_wr, d_addr=16'h0200, d_wdata=16'h1234
//     -> mem_we=1 for one cycle with mem_addr=16'h0200 and mem_wdata=16'h1234; d_ack at cycle 2.
//  4. if_req and d_rd asserted together -> d_ack first; fetch issued in the cycle after
//     IDLE is re-entered; no cycle with mem_re and mem_we both high.
//  5. d_rd=d_wr=1 -> write performed, rw_err=1, still 1 after 10 further idle cycles.
//  6. ARB_FAIRNESS_EN, MAX_STREAK=4, continuous data requests with if_req high
//     -> fetch granted after the 4th data ack; without the macro, fetch is never granted.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/ack and memory-port bundle for mem_port_arbiter
//
// Groups the fetch handshake, the data (load/store) handshake, the memory
// port and the status flags.
//   slave  : arbiter view (requests and mem_rdata in; acks, memory strobes, status out)
//   master : pipeline/memory view (the opposite directions)
interface mem_port_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        stall_if;
  logic        stall_d;
  logic        rw_err;

  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata,
           mem_re, mem_we, stall_if, stall_d, rw_err
  );

  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata,
           mem_re, mem_we, stall_if, stall_d, rw_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fixed-priority arbiter for the shared 16-bit memory port
//
// Shares one memory port between instruction fetch and the execute-stage
// load/store path. Data has priority over fetch; one access in flight.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.if_*   : fetch request/address in, ack pulse and read data out
//   bus.d_*    : data read/write request, address, store data in; ack pulse, load data out
//   bus.mem_*  : memory address/write data/read and write strobes out, read data in
//   bus.stall_if, bus.stall_d : requester waiting (combinational)
//   bus.rw_err : sticky flag, read and write requested together
// Optional feature macro: ARB_FAIRNESS_EN (fetch gets a turn after MAX_STREAK
// data grants in a row while it waits).
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2
`ifdef ARB_FAIRNESS_EN
  ,
  parameter int MAX_STREAK  = 4
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  // Counter only has to hold MEM_LATENCY-1.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t           state;
  logic             grant_d;   // 1: data side owns the access, 0: fetch
  logic             grant_wr;  // access is a write (data side only)
  logic [CNT_W-1:0] cnt;
  logic             data_req;
  logic             fetch_turn;

  assign data_req = bus.d_rd | bus.d_wr;

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [SW-1:0] streak;

  assign fetch_turn = bus.if_req && (streak == SW'(MAX_STREAK));
`else
  assign fetch_turn = 1'b0;
`endif

  assign bus.stall_if = bus.if_req & ~bus.if_ack;
  assign bus.stall_d  = data_req & ~bus.d_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_d       <= 1'b0;
      grant_wr      <= 1'b0;
      cnt           <= '0;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.rw_err    <= 1'b0;
`ifdef ARB_FAIRNESS_EN
      streak        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Strobes are set here so they are high during the ISSUE cycle.
          if (data_req && !fetch_turn) begin
            grant_d       <= 1'b1;
            grant_wr      <= bus.d_wr;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_re    <= ~bus.d_wr;
            bus.mem_we    <= bus.d_wr;
            if (bus.d_rd && bus.d_wr) bus.rw_err <= 1'b1;
`ifdef ARB_FAIRNESS_EN
            if (bus.if_req) streak <= streak + SW'(1);
`endif
            state <= ISSUE;
          end else if (bus.if_req) begin
            grant_d      <= 1'b0;
            grant_wr     <= 1'b0;
            bus.mem_addr <= bus.if_addr;
            bus.mem_re   <= 1'b1;
            bus.mem_we   <= 1'b0;
`ifdef ARB_FAIRNESS_EN
            streak <= '0;
`endif
            state <= ISSUE;
          end
        end

        ISSUE: begin
          bus.mem_re <= 1'b0;
          bus.mem_we <= 1'b0;
          if (grant_wr) begin
            bus.d_ack <= 1'b1;
            state     <= ACK;
          end else begin
            cnt   <= CNT_W'(MEM_LATENCY - 1);
            state <= WAIT;
          end
        end

        WAIT: begin
          // cnt hits 0 in the cycle mem_rdata is valid.
          if (cnt == '0) begin
            if (grant_d) begin
              bus.d_rdata <= bus.mem_rdata;
              bus.d_ack   <= 1'b1;
            end else begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ack   <= 1'b1;
            end
            state <= ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ACK: begin
          // Requests are ignored here so the acked side can drop its request.
          bus.if_ack <= 1'b0;
          bus.d_ack  <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: data valid exactly LAT cycles after the mem_re cycle, garbage otherwise.
  logic [15:0] mem_arr [256];
  logic [15:0] ref_mem [256];
  logic [15:0] pend_addr;
  int          pend_cnt;

  always @(posedge clk) begin
    if (!rst_n) pend_cnt <= 0;
    else if (bus.mem_re) begin
      pend_addr <= bus.mem_addr;
      pend_cnt  <= LAT;
    end else if (pend_cnt != 0) pend_cnt <= pend_cnt - 1;
    if (rst_n && bus.mem_we) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = (pend_cnt == 1) ? mem_arr[pend_addr[7:0]] : 16'hDEAD;

  function automatic logic [15:0] init_val(int i);
    return 16'(i * 257) ^ 16'h3C5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.d_rd   = 1'b0;
    bus.d_wr   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    bit          fetch;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_ack;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  // One isolated transaction; request raised in cycle 0, dropped in its ack cycle.
  task automatic apply_vec(input vec_t v);
    int          ack_at = -1;
    int          strobe_at = -1;
    logic        saw_re = 1'b0, saw_we = 1'b0, wrong_ack = 1'b0;
    logic [15:0] s_addr = '0, s_wdata = '0, rd = '0;
    @(negedge clk);
    if (v.fetch) begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end else begin
      bus.d_rd = v.rd; bus.d_wr = v.wr; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end
    for (int k = 1; k <= 20 && ack_at < 0; k++) begin
      @(negedge clk); #1;
      if ((bus.mem_re || bus.mem_we) && strobe_at < 0) begin
        strobe_at = k; saw_re = bus.mem_re; saw_we = bus.mem_we;
        s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
      end
      if (bus.if_ack || bus.d_ack) begin
        ack_at    = k;
        wrong_ack = v.fetch ? bus.d_ack : bus.if_ack;
        rd        = v.fetch ? bus.if_rdata : bus.d_rdata;
        bus.if_req = 1'b0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
      end
    end
    chk("vec_ack_cycle", 32'(ack_at), 32'(v.exp_ack));
    chk("vec_strobe_cycle", 32'(strobe_at), 32'd1);
    chk("vec_mem_re", {31'd0, saw_re}, {31'd0, ~v.wr});
    chk("vec_mem_we", {31'd0, saw_we}, {31'd0, v.wr});
    chk("vec_mem_addr", {16'd0, s_addr}, {16'd0, v.addr});
    chk("vec_other_ack", {31'd0, wrong_ack}, 32'd0);
    if (v.wr) begin
      chk("vec_mem_wdata", {16'd0, s_wdata}, {16'd0, v.wdata});
      ref_mem[v.addr[7:0]] = v.wdata;
    end else chk("vec_rdata", {16'd0, rd}, {16'd0, v.exp_rdata});
    @(negedge clk); #1;
    chk("vec_stall_if_after", {31'd0, bus.stall_if}, 32'd0);
    chk("vec_acks_after", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
  endtask

  // Random-phase reference model state
  int          cyc, t_free, ack_cyc, strobe_cyc, f_gap, d_gap;
  bit          busy, g_data, g_wr, rw_m, stopping, granted, dq, force_f;
  bit          exp_fa, exp_da;
  logic [15:0] g_addr, g_wdata, g_rdata;
`ifdef ARB_FAIRNESS_EN
  int          streak_m;
`endif

  initial begin
    int          ack_at, d_at, issue_at, f_at, d_cnt, f_cnt;
    bit          both, stall_ok;
    logic [15:0] issue_addr;

    for (int i = 0; i < 256; i++) begin
      mem_arr[i] <= init_val(i);
      ref_mem[i] = init_val(i);
    end
    mem_arr[16] <= 16'hBEEF;
    ref_mem[16] = 16'hBEEF;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 2 + LAT, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0200, 16'h1234, 2,       16'h0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 2 + LAT, 16'h1234};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, 2 + LAT, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h8001, 2,       16'h0000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000, 2 + LAT, 16'h8001};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2 + LAT, 16'hBEEF};

    // Reset with requests pending
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    bus.d_rd = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0040; bus.d_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
    chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 32'd0);
    chk("rst_mem_bus", {bus.mem_addr, bus.mem_wdata}, 32'd0);
    chk("rst_strobes_err", {29'd0, bus.mem_re, bus.mem_we, bus.rw_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_release_mem_re", {31'd0, bus.mem_re}, 32'd1);
    chk("rst_release_addr", {16'd0, bus.mem_addr}, 32'h0040);
    bus.if_req = 1'b0;
    ack_at = -1;
    for (int k = 2; k <= 12 && ack_at < 0; k++) begin
      @(negedge clk); #1;
      if (bus.d_ack) begin ack_at = k; bus.d_rd = 1'b0; end
    end
    chk("rst_release_d_ack", 32'(ack_at), 32'(2 + LAT));
    idle(2);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Read and write together: the write wins, rw_err sticks
    @(negedge clk);
    bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0077; bus.d_wdata = 16'h5555;
    @(negedge clk); #1;
    chk("rw_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd1);
    chk("rw_addr", {bus.mem_addr, bus.mem_wdata}, 32'h0077_5555);
    @(negedge clk); #1;
    chk("rw_d_ack", {31'd0, bus.d_ack}, 32'd1);
    bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    ref_mem[8'h77] = 16'h5555;
    rw_m = 1'b1;
    idle(10);
    #1;
    chk("rw_err_sticky", {31'd0, bus.rw_err}, 32'd1);

    // Randomized traffic against the transaction-level model
    busy = 0; t_free = 0; f_gap = 0; d_gap = 2;
`ifdef ARB_FAIRNESS_EN
    streak_m = 0;
`endif
    for (cyc = 0; cyc < 700; cyc++) begin
      stopping = (cyc >= 620);
      @(negedge clk);
      if (busy && cyc == ack_cyc) begin
        if (g_data) begin
          bus.d_rd = 1'b0; bus.d_wr = 1'b0; d_gap = $urandom_range(0, 3);
        end else begin
          bus.if_req = 1'b0; f_gap = $urandom_range(0, 3);
        end
      end else begin
        if (!bus.if_req && !stopping) begin
          if (f_gap == 0) begin bus.if_req = 1'b1; bus.if_addr = 16'($urandom); end
          else f_gap--;
        end
        if (!(bus.d_rd || bus.d_wr) && !stopping) begin
          if (d_gap == 0) begin
            dq = 1'($urandom_range(0, 1));
            bus.d_rd = ~dq; bus.d_wr = dq;
            bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
          end else d_gap--;
        end
      end
      #1;
      exp_fa = busy && cyc == ack_cyc && !g_data;
      exp_da = busy && cyc == ack_cyc && g_data;
      chk("rnd_if_ack", {31'd0, bus.if_ack}, {31'd0, exp_fa});
      chk("rnd_d_ack", {31'd0, bus.d_ack}, {31'd0, exp_da});
      chk("rnd_mem_re", {31'd0, bus.mem_re}, {31'd0, busy && cyc == strobe_cyc && !g_wr});
      chk("rnd_mem_we", {31'd0, bus.mem_we}, {31'd0, busy && cyc == strobe_cyc && g_wr});
      chk("rnd_stall_if", {31'd0, bus.stall_if}, {31'd0, bus.if_req && !exp_fa});
      chk("rnd_stall_d", {31'd0, bus.stall_d}, {31'd0, (bus.d_rd || bus.d_wr) && !exp_da});
      chk("rnd_rw_err", {31'd0, bus.rw_err}, {31'd0, rw_m});
      if (busy && cyc == strobe_cyc) begin
        chk("rnd_mem_addr", {16'd0, bus.mem_addr}, {16'd0, g_addr});
        if (g_wr) chk("rnd_mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, g_wdata});
      end
      if (exp_fa) chk("rnd_if_rdata", {16'd0, bus.if_rdata}, {16'd0, g_rdata});
      if (exp_da && !g_wr) chk("rnd_d_rdata", {16'd0, bus.d_rdata}, {16'd0, g_rdata});
      if (busy && cyc == ack_cyc) begin busy = 0; t_free = cyc + 1; end
      if (!busy && cyc >= t_free) begin
        granted = 0;
        dq = bus.d_rd || bus.d_wr;
        force_f = 0;
`ifdef ARB_FAIRNESS_EN
        force_f = bus.if_req && streak_m == MAXS;
`endif
        if (dq && !force_f) begin
          granted = 1; g_data = 1; g_wr = bus.d_wr; g_addr = bus.d_addr; g_wdata = bus.d_wdata;
          if (bus.d_rd && bus.d_wr) rw_m = 1;
`ifdef ARB_FAIRNESS_EN
          if (bus.if_req) streak_m++;
`endif
        end else if (bus.if_req) begin
          granted = 1; g_data = 0; g_wr = 0; g_addr = bus.if_addr;
`ifdef ARB_FAIRNESS_EN
          streak_m = 0;
`endif
        end
        if (granted) begin
          busy = 1;
          strobe_cyc = cyc + 1;
          ack_cyc = cyc + (g_wr ? 2 : 2 + LAT);
          if (g_wr) ref_mem[g_addr[7:0]] = g_wdata;
          else g_rdata = ref_mem[g_addr[7:0]];
        end
      end
    end
    idle(3);

    // Clear any fairness streak with a lone fetch, then fetch and data together
    apply_vec(vecs[0]);
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 16'h0020; bus.d_rd = 1'b1; bus.d_addr = 16'h0030;
    d_at = -1; issue_at = -1; f_at = -1; both = 0; stall_ok = 1; issue_addr = '0;
    for (int k = 1; k <= 30 && f_at < 0; k++) begin
      @(negedge clk); #1;
      if (bus.mem_re && bus.mem_we) both = 1;
      if (bus.d_ack && d_at < 0) begin d_at = k; bus.d_rd = 1'b0; end
      if (d_at >= 0 && bus.mem_re && issue_at < 0) begin issue_at = k; issue_addr = bus.mem_addr; end
      if (bus.if_ack) begin f_at = k; bus.if_req = 1'b0; end
      else if (!bus.stall_if) stall_ok = 0;
    end
    chk("both_d_ack_cycle", 32'(d_at), 32'(2 + LAT));
    chk("both_fetch_issue", 32'(issue_at), 32'(4 + LAT));
    chk("both_fetch_addr", {16'd0, issue_addr}, 32'h0020);
    chk("both_if_ack_cycle", 32'(f_at), 32'(5 + 2 * LAT));
    chk("both_no_re_we", {31'd0, both}, 32'd0);
    chk("both_stall_if_held", {31'd0, stall_ok}, 32'd1);
    idle(2);

    // Continuous data reads with fetch waiting
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; bus.d_rd = 1'b1; bus.d_addr = 16'h0005;
    d_cnt = 0; f_cnt = 0;
    for (int k = 1; k <= 100 && f_cnt == 0; k++) begin
      @(negedge clk); #1;
      if (bus.d_ack) d_cnt++;
      if (bus.if_ack) f_cnt++;
    end
`ifdef ARB_FAIRNESS_EN
    chk("fair_fetch_granted", 32'(f_cnt), 32'd1);
    chk("fair_data_acks_before", 32'(d_cnt), 32'(MAXS));
`else
    chk("strict_no_fetch", 32'(f_cnt), 32'd0);
    chk("strict_data_flowing", {31'd0, d_cnt >= 10}, 32'd1);
`endif
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
